// File: rtl/game_sequencer.sv
// Breakout game flow: monitor-sync wait, serve, play, life/level bookkeeping, game over/won.
// Optional GAME_SEQUENCER_AUTO_SERVE_EN: serve after the pause with no button press.
module game_sequencer #(
    parameter int unsigned START_DELAY_CYC = 100000000,
    parameter int unsigned NUM_LIVES       = 3,
    parameter int unsigned NUM_LEVELS      = 4,
    parameter int unsigned PAUSE_FRAMES    = 60
) (
    input  logic       pxl_clk,
    input  logic       reset,
    input  logic       vsync,
    input  logic       win,
    input  logic       lose,
    input  logic       serve_btn,
    output logic       start,
    output logic       ball_reset,
    output logic       blocks_reset,
    output logic [3:0] lives,
    output logic [3:0] level,
    output logic [2:0] state,
    output logic       game_over,
    output logic       game_won
);
    localparam int unsigned DLY_W = (START_DELAY_CYC > 1) ? $clog2(START_DELAY_CYC) : 1;
    localparam logic [DLY_W-1:0] DLY_LAST   = DLY_W'(START_DELAY_CYC - 1);
    localparam logic [7:0]       PAUSE_INIT = 8'(PAUSE_FRAMES);
    localparam logic [3:0]       LIVES_INIT = 4'(NUM_LIVES);
    localparam logic [3:0]       LEVEL_LAST = 4'(NUM_LEVELS - 1);

    typedef enum logic [2:0] {
        S_WAIT_SYNC = 3'd0,
        S_SERVE     = 3'd1,
        S_PLAY      = 3'd2,
        S_LOST      = 3'd3,
        S_LEVEL_UP  = 3'd4,
        S_OVER      = 3'd5,
        S_WON       = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic [7:0]       frame_q, frame_d, frame_dec;
    logic [3:0]       lives_q, lives_d;
    logic [3:0]       level_q, level_d;
    logic             start_q, start_d;
    logic             ball_reset_q, ball_reset_d;
    logic             blocks_reset_q, blocks_reset_d;
    logic             game_over_q, game_over_d;
    logic             game_won_q, game_won_d;
    logic             frame_tick_q, frame_tick_d;
    logic             vsync_r1_q, vsync_r2_q;
    logic             serve_s1_q, serve_s2_q, serve_s3_q;
    logic             win_r_q, win_h_q, lose_r_q, lose_h_q;
    logic             serve_rise, win_rise, lose_rise, serve_ok;
`ifndef GAME_SEQUENCER_AUTO_SERVE_EN
    logic             serve_seen_q, serve_seen_d;
`endif

    assign serve_rise = serve_s2_q & ~serve_s3_q;
    assign win_rise   = win_r_q & ~win_h_q;
    assign lose_rise  = lose_r_q & ~lose_h_q;

    always_comb begin
        state_d        = state_q;
        dly_d          = dly_q;
        frame_d        = frame_q;
        lives_d        = lives_q;
        level_d        = level_q;
        ball_reset_d   = 1'b0;
        blocks_reset_d = 1'b0;
        frame_tick_d   = vsync_r2_q & ~vsync_r1_q;
        frame_dec      = (frame_tick_q && frame_q != 8'd0) ? frame_q - 8'd1 : frame_q;
`ifdef GAME_SEQUENCER_AUTO_SERVE_EN
        serve_ok       = 1'b1;
`else
        serve_seen_d   = serve_seen_q | serve_rise;
        serve_ok       = serve_seen_q | serve_rise;
`endif
        case (state_q)
            S_WAIT_SYNC: begin
                if (dly_q == DLY_LAST) begin
                    ball_reset_d   = 1'b1;
                    blocks_reset_d = 1'b1;
                    state_d        = S_SERVE;
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            S_SERVE: begin
                frame_d = frame_dec;
                if (frame_q == 8'd0 && serve_ok) state_d = S_PLAY;
            end
            S_PLAY: begin
                // A win on the same cycle as a miss takes precedence and spares the life.
                if (win_rise) begin
                    if (level_q >= LEVEL_LAST) begin
                        state_d = S_WON;
                    end else begin
                        level_d = level_q + 4'd1;
                        state_d = S_LEVEL_UP;
                    end
                end else if (lose_rise) begin
                    if (lives_q != 4'd0) lives_d = lives_q - 4'd1;
                    state_d = (lives_q <= 4'd1) ? S_OVER : S_LOST;
                end
            end
            S_LOST: begin
                frame_d = frame_dec;
                if (frame_q == 8'd0) begin
                    ball_reset_d = 1'b1;
                    state_d      = S_SERVE;
                end
            end
            S_LEVEL_UP: begin
                frame_d = frame_dec;
                if (frame_q == 8'd0) begin
                    ball_reset_d   = 1'b1;
                    blocks_reset_d = 1'b1;
                    state_d        = S_SERVE;
                end
            end
            S_OVER, S_WON: begin
                if (serve_rise) begin
                    lives_d        = LIVES_INIT;
                    level_d        = 4'd0;
                    ball_reset_d   = 1'b1;
                    blocks_reset_d = 1'b1;
                    state_d        = S_SERVE;
                end
            end
            default: state_d = S_WAIT_SYNC;
        endcase

        // Every entry into a pause state restarts the frame count and forgets earlier presses.
        if (state_d != state_q &&
            (state_d == S_SERVE || state_d == S_LOST || state_d == S_LEVEL_UP)) begin
            frame_d = PAUSE_INIT;
`ifndef GAME_SEQUENCER_AUTO_SERVE_EN
            serve_seen_d = 1'b0;
`endif
        end

        start_d     = (state_d == S_PLAY);
        game_over_d = (state_d == S_OVER);
        game_won_d  = (state_d == S_WON);
    end

    always_ff @(posedge pxl_clk) begin
        if (reset) begin
            state_q        <= S_WAIT_SYNC;
            dly_q          <= '0;
            frame_q        <= 8'd0;
            lives_q        <= LIVES_INIT;
            level_q        <= 4'd0;
            start_q        <= 1'b0;
            ball_reset_q   <= 1'b0;
            blocks_reset_q <= 1'b0;
            game_over_q    <= 1'b0;
            game_won_q     <= 1'b0;
            frame_tick_q   <= 1'b0;
            vsync_r1_q     <= 1'b1;
            vsync_r2_q     <= 1'b1;
            serve_s1_q     <= 1'b0;
            serve_s2_q     <= 1'b0;
            serve_s3_q     <= 1'b0;
            win_r_q        <= 1'b0;
            win_h_q        <= 1'b0;
            lose_r_q       <= 1'b0;
            lose_h_q       <= 1'b0;
`ifndef GAME_SEQUENCER_AUTO_SERVE_EN
            serve_seen_q   <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            dly_q          <= dly_d;
            frame_q        <= frame_d;
            lives_q        <= lives_d;
            level_q        <= level_d;
            start_q        <= start_d;
            ball_reset_q   <= ball_reset_d;
            blocks_reset_q <= blocks_reset_d;
            game_over_q    <= game_over_d;
            game_won_q     <= game_won_d;
            frame_tick_q   <= frame_tick_d;
            vsync_r1_q     <= vsync;
            vsync_r2_q     <= vsync_r1_q;
            serve_s1_q     <= serve_btn;
            serve_s2_q     <= serve_s1_q;
            serve_s3_q     <= serve_s2_q;
            win_r_q        <= win;
            win_h_q        <= win_r_q;
            lose_r_q       <= lose;
            lose_h_q       <= lose_r_q;
`ifndef GAME_SEQUENCER_AUTO_SERVE_EN
            serve_seen_q   <= serve_seen_d;
`endif
        end
    end

    assign start        = start_q;
    assign ball_reset   = ball_reset_q;
    assign blocks_reset = blocks_reset_q;
    assign lives        = lives_q;
    assign level        = level_q;
    assign state        = state_q;
    assign game_over    = game_over_q;
    assign game_won     = game_won_q;
endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter START_DELAY_CYC, default 100000000, giving pxl_clk cycles of monitor-sync wait after reset.
REQ-002 SHALL have parameter NUM_LIVES, default 3, giving balls per game (1..15).
REQ-003 SHALL have parameter NUM_LEVELS, default 4, giving levels per game (1..15).
REQ-004 SHALL have parameter PAUSE_FRAMES, default 60, giving frames held in SERVE/LOST/LEVEL_UP (1..255).
REQ-005 SHALL have ports: pxl_clk in 1 pixel clock (25 MHz), the only clock; reset in 1 synchronous active-high reset.
REQ-006 SHALL have ports: vsync in 1 active-low VGA vsync; win in 1 level, block field cleared; lose in 1 level, ball missed paddle; serve_btn in 1 asynchronous serve button.
REQ-007 SHALL have ports: start out 1 ball motion enable; ball_reset out 1 one-cycle ball re-centre pulse; blocks_reset out 1 one-cycle block field restore pulse.
REQ-008 SHALL have ports: lives out 4 remaining balls; level out 4 current level, 0-based; state out 3 FSM state code; game_over out 1; game_won out 1.

Function
REQ-009 SHALL derive frame_tick as one-cycle pulse the cycle after a registered 1->0 transition of vsync.
REQ-010 SHALL pass serve_btn through a 2-flop synchroniser and use its registered rising edge only.
REQ-011 SHALL edge-detect win and lose (registered 0->1) and act only on those edges.
REQ-012 SHALL implement states WAIT_SYNC=0, SERVE=1, PLAY=2, LOST=3, LEVEL_UP=4, OVER=5, WON=6, driven on state.
REQ-013 WAIT_SYNC: count pxl_clk cycles; at count==START_DELAY_CYC-1 pulse ball_reset and blocks_reset, go SERVE.
REQ-014 SERVE/LOST/LEVEL_UP SHALL load an 8-bit frame counter with PAUSE_FRAMES on entry, decrement on frame_tick, saturate at 0.
REQ-015 SERVE -> PLAY when frame counter is 0 and serve condition (REQ-030) met; start asserts the same cycle as state==PLAY.
REQ-016 start SHALL be 1 only in PLAY; deasserts the cycle after a win/lose edge is taken.
REQ-017 PLAY on lose edge: decrement lives; if lives was 1 go OVER, else go LOST.
REQ-018 PLAY on win edge: if level==NUM_LEVELS-1 go WON, else increment level and go LEVEL_UP.
REQ-019 Simultaneous win and lose edges in PLAY SHALL be treated as win only; lives unchanged.
REQ-020 LOST -> SERVE when frame counter reaches 0, pulsing ball_reset only.
REQ-021 LEVEL_UP -> SERVE when frame counter reaches 0, pulsing ball_reset and blocks_reset together.
REQ-022 OVER/WON hold; game_over=1 only in OVER, game_won=1 only in WON; serve_btn edge restarts: lives=NUM_LIVES, level=0, pulse ball_reset and blocks_reset, go SERVE.
REQ-023 win/lose edges outside PLAY SHALL be ignored; lives SHALL never underflow below 0 nor level exceed NUM_LEVELS-1.
REQ-024 Pulses SHALL be exactly one pxl_clk cycle, registered outputs, no combinational input-to-output path.

Reset
REQ-025 reset SHALL be sampled only on pxl_clk rising edge and override all other events.
REQ-026 On reset: state=WAIT_SYNC, delay count=0, frame counter=0, lives=NUM_LIVES, level=0.
REQ-027 On reset: start=0, ball_reset=0, blocks_reset=0, game_over=0, game_won=0, all edge-detect/synchroniser flops=0 (vsync history=1).
REQ-028 Reset asserted mid-PLAY SHALL drop start the next cycle and restart the full START_DELAY_CYC wait.

Configuration
REQ-029 SHALL support macro GAME_SEQUENCER_AUTO_SERVE_EN.
REQ-030 Defined: serve condition is frame counter 0 alone, serve_btn ignored in SERVE. Undefined: serve condition also requires a synchronised serve_btn rising edge, captured and held once seen while counter nonzero. OVER/WON restart behaviour identical in both builds.

Verification (bench uses START_DELAY_CYC=20, PAUSE_FRAMES=2, NUM_LIVES=2, NUM_LEVELS=2)
REQ-031 Reset release -> state=0 for 20 cycles, then ball_reset=blocks_reset=1 for one cycle, state=1, lives=2, level=0.
REQ-032 In SERVE, 2 vsync falling edges (+ serve_btn pulse if macro undefined) -> state=2, start=1; without serve_btn (macro undefined) state stays 1.
REQ-033 PLAY, lose rises -> start=0 next cycle, lives=1, state=3; after 2 frames ball_reset pulse, state=1; second lose in PLAY -> lives=0, state=5, game_over=1.
REQ-034 PLAY level 0, win and lose rise same cycle -> lives unchanged, level=1, state=4; after 2 frames both reset pulses; win at level 1 -> state=6, game_won=1.
REQ-035 State 5, serve_btn pulse -> lives=2, level=0, both reset pulses, state=1; win/lose toggled in state 1 -> no change.
REQ-036 reset asserted one cycle during PLAY -> start=0 next cycle, state=0, full 20-cycle wait repeats.
